// File: rtl/fpu_cmd_sched.sv
// Command scheduler owning every fpu control input: FIFO, load/exec sequencing, host writes.
// Optional watchdog on EXEC is enabled by defining FPU_TIMEOUT_EN.
module fpu_cmd_sched #(
  parameter int DEPTH        = 4,
  parameter int LD_CYCLES    = 2,
  parameter int SCRATCH_ADDR = 31,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_opcode,
  input  logic [4:0]  cmd_src1,
  input  logic [4:0]  cmd_src2,
  input  logic [4:0]  cmd_dst,
  input  logic        wr_req,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  input  logic [31:0] fpu_out,
  input  logic        fpu_done,
  input  logic [7:0]  fpu_flags,
  output logic        fpu_enable,
  output logic        fpu_ld,
  output logic [2:0]  fpu_opcode,
  output logic [4:0]  fpu_addr1,
  output logic [4:0]  fpu_addr2,
  output logic [4:0]  fpu_addr3,
  output logic [31:0] fpu_inp,
  output logic        rsp_valid,
  output logic [31:0] rsp_result,
  output logic [7:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic [4:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LD_CYCLES + 1);
  localparam logic [4:0] SCR = 5'(SCRATCH_ADDR);

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] d;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_EXEC, S_RET
  } state_t;

  cmd_t          fifo_q [DEPTH];
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   occ, occ_d;
  logic          rdy_q, rdy_d;
  state_t        state_q, state_d;
  logic [LW-1:0] ld_q, ld_d;
  logic [2:0]    opc_q, opc_d;
  logic [31:0]   res_q, res_d;
  logic [7:0]    flg_q, flg_d;
  logic [4:0]    stk_q, stk_d;
  logic          push, pop, empty, tmo_hit, tmo_q;
  cmd_t          head;

  assign push  = cmd_valid & rdy_q;
  assign pop   = (state_q == S_RET);
  assign occ   = wp_q - rp_q;
  assign empty = (occ == '0);
  assign head  = fifo_q[rp_q[AW-1:0]];
  assign wp_d  = wp_q + {{AW{1'b0}}, push};
  assign rp_d  = rp_q + {{AW{1'b0}}, pop};
  assign occ_d = wp_d - rp_d;
  assign rdy_d = (occ_d != (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q[AW-1:0]] <= {cmd_opcode, cmd_src1, cmd_src2, cmd_dst};
  end

`ifdef FPU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tc_q, tc_d;

  always_comb begin
    tc_d = '0;
    if (state_q == S_EXEC) tc_d = tc_q + 1'b1;
  end

  // fpu_done on the last allowed cycle still counts as a normal finish
  assign tmo_hit = (state_q == S_EXEC) && !fpu_done && (tc_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      tmo_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_q   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    opc_d      = opc_q;
    res_d      = res_q;
    flg_d      = flg_q;
    fpu_enable = 1'b0;
    fpu_ld     = 1'b0;
    fpu_addr1  = SCR;
    fpu_addr2  = '0;
    fpu_addr3  = SCR;
    fpu_inp    = '0;
    wr_ack     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          fpu_addr1 = wr_addr;
          fpu_inp   = wr_data;
          wr_ack    = 1'b1;
        end else if (!empty) begin
          opc_d = head.op;
          if (head.op <= 3'd4) begin
            state_d = S_LOAD;
            ld_d    = '0;
          end else begin
            state_d = S_RET;
            res_d   = '0;
            flg_d   = 8'h20;
          end
        end
      end
      S_LOAD: begin
        fpu_enable = 1'b1;
        fpu_ld     = 1'b1;
        fpu_addr1  = head.s1;
        fpu_addr2  = head.s2;
        fpu_addr3  = head.d;
        if (ld_q == LW'(LD_CYCLES - 1)) state_d = S_EXEC;
        else ld_d = ld_q + 1'b1;
      end
      S_EXEC: begin
        fpu_enable = 1'b1;
        fpu_addr1  = head.s1;
        fpu_addr2  = head.s2;
        fpu_addr3  = head.d;
        if (fpu_done) begin
          state_d = S_RET;
          res_d   = (opc_q == 3'd4) ? 32'h0 : fpu_out;
          flg_d   = fpu_flags;
        end else if (tmo_hit) begin
          state_d = S_RET;
          res_d   = '0;
          flg_d   = '0;
        end
      end
      S_RET: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_valid    = (state_q == S_RET);
  assign rsp_result   = rsp_valid ? res_q : 32'h0;
  assign rsp_flags    = rsp_valid ? flg_q : 8'h0;
  assign rsp_timeout  = rsp_valid & tmo_q;
  // clear has priority over a same-cycle accumulate
  assign stk_d        = sticky_clr ? 5'h0 : (stk_q | rsp_flags[7:3]);
  assign sticky_flags = stk_q;
  assign fpu_opcode   = opc_q;
  assign cmd_ready    = rdy_q;
  assign busy         = (state_q != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      rdy_q   <= 1'b1;
      state_q <= S_IDLE;
      ld_q    <= '0;
      opc_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      stk_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      rdy_q   <= rdy_d;
      state_q <= state_d;
      ld_q    <= ld_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      stk_q   <= stk_d;
    end
  end

endmodule
